// File: rtl/game_state_ctrl.sv
// Frame-synchronous game supervisor: attract, countdown, play, hit/invulnerability, game over.
module game_state_ctrl #(
    parameter int unsigned MAX_LIVES     = 3,
    parameter int unsigned LIVES_W       = 2,
    parameter int unsigned SCORE_W       = 8,
    parameter int unsigned KILL_POINTS   = 1,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned START_FRAMES  = 30,
    parameter int unsigned FLASH_HALF    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_end,
    input  logic               player_hit,
    input  logic               sword_hit,
    input  logic               sheep_eaten,
    input  logic               start_btn,
    output logic [2:0]         state,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score,
    output logic               game_active,
    output logic               player_visible,
    output logic               entity_reset,
    output logic               dragon_grow
);

    localparam int unsigned CNT_MAX = (INVULN_FRAMES > START_FRAMES) ? INVULN_FRAMES : START_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned FLASH_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam int unsigned SUM_W   = SCORE_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_PLAY  = 3'd2,
        S_HIT   = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [LIVES_W-1:0]   lives_d;
    logic [SCORE_W-1:0]   score_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FLASH_W-1:0]   flash_q, flash_d;
    logic                 visible_d, active_d, ereset_d, grow_d;

    logic                 sync1, sync2, sync_prev;
    logic                 start_edge, start_lat, start_any;
    logic                 hit_lat, sword_lat, sheep_lat;
    logic                 hit_any, sword_any, sheep_any;
    logic [SUM_W-1:0]     score_sum;
    logic [SCORE_W-1:0]   score_sat;

    assign state = state_q;

    // Start button synchroniser and previous-value flop for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= start_btn;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign start_edge = sync2 & ~sync_prev;

    // Sticky per-frame latches, cleared when the frame is evaluated
    always_ff @(posedge clk) begin
        if (!rst_n || frame_end) begin
            start_lat <= 1'b0;
            hit_lat   <= 1'b0;
            sword_lat <= 1'b0;
            sheep_lat <= 1'b0;
        end else begin
            start_lat <= start_lat | start_edge;
            hit_lat   <= hit_lat   | player_hit;
            sword_lat <= sword_lat | sword_hit;
            sheep_lat <= sheep_lat | sheep_eaten;
        end
    end

    // Events arriving on the frame_end cycle belong to the frame that is ending
    assign start_any = start_lat | start_edge;
    assign hit_any   = hit_lat   | player_hit;
    assign sword_any = sword_lat | sword_hit;
    assign sheep_any = sheep_lat | sheep_eaten;

    // Saturating score increment; the carry bit flags overflow past all-ones
    assign score_sum = {1'b0, score} + SUM_W'(KILL_POINTS);
    assign score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            lives          <= LIVES_W'(MAX_LIVES);
            score          <= '0;
            cnt_q          <= '0;
            flash_q        <= '0;
            player_visible <= 1'b1;
            game_active    <= 1'b0;
            entity_reset   <= 1'b0;
            dragon_grow    <= 1'b0;
        end else begin
            state_q        <= state_d;
            lives          <= lives_d;
            score          <= score_d;
            cnt_q          <= cnt_d;
            flash_q        <= flash_d;
            player_visible <= visible_d;
            game_active    <= active_d;
            entity_reset   <= ereset_d;
            dragon_grow    <= grow_d;
        end
    end

    // Next-state and output logic, evaluated only on frame_end
    always_comb begin
        state_d   = state_q;
        lives_d   = lives;
        score_d   = score;
        cnt_d     = cnt_q;
        flash_d   = flash_q;
        visible_d = player_visible;
        active_d  = game_active;
        ereset_d  = 1'b0;
        grow_d    = 1'b0;

        if (frame_end) begin
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (start_any) begin
                        state_d   = S_START;
                        lives_d   = LIVES_W'(MAX_LIVES);
                        score_d   = '0;
                        cnt_d     = CNT_W'(START_FRAMES);
                        ereset_d  = 1'b1;
                        visible_d = 1'b1;
                        active_d  = 1'b0;
                    end
                end

                S_START: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d  = S_PLAY;
                        cnt_d    = '0;
                        active_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end

                S_PLAY: begin
                    if (sword_any) score_d = score_sat;
                    if (sheep_any) grow_d = 1'b1;
                    if (hit_any) begin
                        if (lives > LIVES_W'(1)) begin
                            lives_d   = lives - LIVES_W'(1);
                            state_d   = S_HIT;
                            cnt_d     = CNT_W'(INVULN_FRAMES);
                            flash_d   = '0;
                            visible_d = 1'b0;
                        end else begin
                            lives_d  = '0;
                            state_d  = S_OVER;
                            active_d = 1'b0;
                        end
                    end
                end

                S_HIT: begin
                    if (sword_any) score_d = score_sat;
                    if (sheep_any) grow_d = 1'b1;
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d   = S_PLAY;
                        cnt_d     = '0;
                        visible_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (flash_q == FLASH_W'(FLASH_HALF - 1)) begin
                            flash_d   = '0;
                            visible_d = ~player_visible;
                        end else begin
                            flash_d = flash_q + FLASH_W'(1);
                        end
                    end
                end

                default: begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    visible_d = 1'b1;
                    active_d  = 1'b0;
                end
            endcase
        end
    end

endmodule
